// File: rtl/iic_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iic_txn_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one AXI-to-IIC transaction
//            engine among NUM_REQ requesters, with a hung-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module iic_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CMD_W          = 32,
    parameter int INIT_PULSE     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic                     timeout,
    output logic                     busy,
    output logic [CMD_W-1:0]         eng_cmd,
    output logic                     eng_init,
    input  logic                     eng_done,
    input  logic                     eng_error,
    output logic [15:0]              txn_count
);

    localparam int c_ptr_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_max = (INIT_PULSE > TIMEOUT_CYCLES) ? INIT_PULSE : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_init_last = c_cnt_w'(INIT_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_to_last   = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_last_req  = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [c_ptr_w-1:0]   r_ptr, w_ptr_nxt;
    logic [c_ptr_w-1:0]   r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic [NUM_REQ-1:0]   r_err, w_err_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic [CMD_W-1:0]     r_eng_cmd, w_eng_cmd_nxt;
    logic [15:0]          r_txn_count, w_txn_count_nxt;
    logic                 r_done_prev;

    logic                 w_sel_valid;
    logic [c_ptr_w-1:0]   w_sel_idx;
    logic [NUM_REQ-1:0]   w_sel_onehot;
    logic [CMD_W-1:0]     w_sel_cmd;
    logic                 w_done_rise;

    // Descending scan so the last hit is the nearest set bit at/after r_ptr.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = c_ptr_w'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
        w_sel_onehot[w_sel_idx] = 1'b1;
        w_sel_cmd = req_cmd[int'(w_sel_idx)*CMD_W +: CMD_W];
    end

    assign w_done_rise = eng_done & ~r_done_prev;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_grant_nxt     = r_grant;
        w_eng_cmd_nxt   = r_eng_cmd;
        w_txn_count_nxt = r_txn_count;
        w_done_nxt      = '0;
        w_err_nxt       = '0;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_owner_nxt   = w_sel_idx;
                    w_grant_nxt   = w_sel_onehot;
                    w_eng_cmd_nxt = w_sel_cmd;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (r_cnt == c_init_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + c_cnt_one;
                // A real completion in the last watchdog cycle takes precedence.
                if (w_done_rise) begin
                    w_done_nxt      = r_grant;
                    w_err_nxt       = eng_error ? r_grant : '0;
                    w_txn_count_nxt = r_txn_count + 16'd1;
                    w_state_nxt     = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_to_last)) begin
                    w_done_nxt      = r_grant;
                    w_err_nxt       = r_grant;
                    w_timeout_nxt   = 1'b1;
                    w_txn_count_nxt = r_txn_count + 16'd1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                w_grant_nxt = '0;
                w_ptr_nxt   = (r_owner == c_last_req) ? '0 : r_owner + c_ptr_one;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_timeout   <= 1'b0;
            r_eng_cmd   <= '0;
            r_txn_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_eng_cmd   <= w_eng_cmd_nxt;
            r_txn_count <= w_txn_count_nxt;
        end
    end

    // Tracks the engine level through reset too, so a held level never looks like an edge.
    always_ff @(posedge ACLK) begin
        r_done_prev <= eng_done;
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign err       = r_err;
    assign timeout   = r_timeout;
    assign busy      = (r_state != S_IDLE);
    assign eng_init  = (r_state == S_LAUNCH);
    assign eng_cmd   = r_eng_cmd;
    assign txn_count = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_iic_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_txn_arbiter
// Brief    : Self-checking bench for iic_txn_arbiter with an engine model and
//            a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_txn_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IP = 2;
    localparam int TO = 16;

    logic           ACLK;
    logic           ARESETN;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_cmd;
    logic [N-1:0]   grant, done, err;
    logic           timeout, busy, eng_init, eng_done, eng_error;
    logic [W-1:0]   eng_cmd;
    logic [15:0]    txn_count;

    int checks   = 0;
    int failures = 0;

    bit   eng_auto    = 1'b0;
    int   eng_delay   = 0;
    bit   eng_err_val = 1'b0;
    int   eng_cd      = 0;
    int   eng_hi      = 0;
    logic eng_init_q  = 1'b0;

    bit           mon_en = 1'b0;
    int           mon_done_pulses = 0;
    logic [N-1:0] mon_prev_done = '0;

    int m_ptr   = 0;
    int m_count = 0;

    iic_txn_arbiter #(
        .NUM_REQ(N), .CMD_W(W), .INIT_PULSE(IP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .req_cmd(req_cmd),
        .grant(grant), .done(done), .err(err), .timeout(timeout), .busy(busy),
        .eng_cmd(eng_cmd), .eng_init(eng_init), .eng_done(eng_done),
        .eng_error(eng_error), .txn_count(txn_count)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    // Reference: first requester at or after the pointer, modulo N.
    function automatic int m_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    // Cycles from WAIT entry to done: edge+1, capped by the watchdog.
    function automatic int exp_lat(input int d);
        if (d == 0) return TO;
        return (d + 1 < TO) ? d + 1 : TO;
    endfunction

    function automatic bit exp_to(input int d);
        return (d == 0) || (d + 1 > TO);
    endfunction

    // One clock: advance, then run the engine model.
    task automatic step();
        @(posedge ACLK);
        #1;
        if (eng_auto) begin
            if (eng_done && (done != 0 || eng_hi >= 3)) begin
                eng_done = 1'b0; eng_error = 1'b0; eng_hi = 0;
            end else if (eng_done) begin
                eng_hi++;
            end
            if (eng_init_q && !eng_init && eng_delay > 0) begin
                eng_cd = eng_delay;
            end else if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    eng_done = 1'b1; eng_error = eng_err_val; eng_hi = 0;
                end
            end
        end
        eng_init_q = eng_init;
    endtask

    // Runs one transaction from IDLE with requests already driven; only observes.
    task automatic do_txn(input int delay, input bit e, input bit drop, input bit scramble,
                          output logic [N-1:0] g, output logic [W-1:0] cmd0,
                          output logic [W-1:0] cmd1, output int glat, output int ilen,
                          output int lat, output logic [N-1:0] d, output logic [N-1:0] er,
                          output logic to, output logic [15:0] cnt);
        int own;
        eng_auto = 1'b1; eng_delay = delay; eng_err_val = e;
        glat = 0;
        while (grant == 0 && glat < 20) begin step(); glat++; end
        g = grant; cmd0 = eng_cmd; own = 0;
        for (int i = 0; i < N; i++) if (grant[i]) own = i;
        if (scramble) req_cmd[own*W +: W] = $urandom;
        ilen = 0;
        while (eng_init === 1'b1 && ilen < 20) begin step(); ilen++; end
        lat = 0;
        while (done == 0 && lat < 100) begin step(); lat++; end
        d = done; er = err; to = timeout; cnt = txn_count; cmd1 = eng_cmd;
        if (drop) req = req & ~done;
        step();
    endtask

    always @(negedge ACLK) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(grant)) begin failures++; $display("FAIL inv_grant_onehot0 act=%b", grant); end
            if (done != 0) begin
                mon_done_pulses++;
                checks++;
                if (done !== grant || mon_prev_done != 0) begin
                    failures++; $display("FAIL inv_done_owner act=%b grant=%b prev=%b", done, grant, mon_prev_done);
                end
            end else begin
                checks++;
                if (err !== '0 || timeout !== 1'b0) begin
                    failures++; $display("FAIL inv_flags_outside_resp err=%b to=%b exp=0", err, timeout);
                end
            end
            mon_prev_done = done;
        end
    end

    task automatic test_reset();
        ARESETN = 1'b0; req = '0; req_cmd = '0; eng_done = 1'b0; eng_error = 1'b0;
        step(); step();
        checks++; if (grant !== '0 || done !== '0 || err !== '0 || timeout !== 1'b0) begin
            failures++; $display("FAIL reset_flags g=%b d=%b e=%b t=%b exp=0", grant, done, err, timeout); end
        checks++; if (busy !== 1'b0 || eng_init !== 1'b0) begin
            failures++; $display("FAIL reset_busy_init busy=%b init=%b exp=0", busy, eng_init); end
        checks++; if (eng_cmd !== '0 || txn_count !== '0) begin
            failures++; $display("FAIL reset_cmd_count cmd=%h cnt=%0d exp=0", eng_cmd, txn_count); end
        ARESETN = 1'b1; mon_en = 1'b1;
    endtask

    task automatic test_contention();
        logic [N-1:0] g, d, er; logic [W-1:0] c0, c1; int gl, il, lt; logic to; logic [15:0] cn;
        logic [N-1:0] seq [5];
        int p0;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) req_cmd[i*W +: W] = 32'hC000_0000 + i;
        p0 = mon_done_pulses;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_txn(3 + k, 1'b0, 1'b0, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
            m_count++;
            checks++; if (g !== seq[k]) begin failures++; $display("FAIL cont_grant[%0d] act=%b exp=%b", k, g, seq[k]); end
            checks++; if (d !== seq[k] || er !== '0 || to !== 1'b0) begin
                failures++; $display("FAIL cont_done[%0d] d=%b e=%b t=%b exp_d=%b", k, d, er, to, seq[k]); end
            checks++; if (lt != 4 + k) begin failures++; $display("FAIL cont_lat[%0d] act=%0d exp=%0d", k, lt, 4 + k); end
            checks++; if (cn !== 16'(m_count)) begin failures++; $display("FAIL cont_count[%0d] act=%0d exp=%0d", k, cn, m_count); end
        end
        req = '0; m_ptr = 1;
        checks++; if (mon_done_pulses != p0 + 5) begin
            failures++; $display("FAIL cont_done_pulses act=%0d exp=%0d", mon_done_pulses - p0, 5); end
    endtask

    task automatic test_single();
        logic [N-1:0] g, d, er; logic [W-1:0] c0, c1; int gl, il, lt; logic to; logic [15:0] cn;
        req_cmd[0 +: W] = 32'hA5A5_0001;
        req = 4'b0001;
        do_txn(8, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++; m_ptr = 1;
        checks++; if (gl != 1 || g !== 4'b0001) begin failures++; $display("FAIL single_grant lat=%0d g=%b exp=1/0001", gl, g); end
        checks++; if (il != IP) begin failures++; $display("FAIL single_init_len act=%0d exp=%0d", il, IP); end
        checks++; if (c0 !== 32'hA5A5_0001) begin failures++; $display("FAIL single_cmd act=%h exp=a5a50001", c0); end
        checks++; if (lt != 9) begin failures++; $display("FAIL single_done_lat act=%0d exp=9", lt); end
        checks++; if (d !== 4'b0001 || er !== 4'b0000 || to !== 1'b0) begin
            failures++; $display("FAIL single_done d=%b e=%b t=%b exp=0001/0000/0", d, er, to); end
        checks++; if (cn !== 16'(m_count)) begin failures++; $display("FAIL single_count act=%0d exp=%0d", cn, m_count); end
    endtask

    task automatic test_error();
        logic [N-1:0] g, d, er; logic [W-1:0] c0, c1; int gl, il, lt; logic to; logic [15:0] cn;
        req = 4'b0100;
        do_txn(5, 1'b1, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++;
        checks++; if (d !== 4'b0100 || er !== 4'b0100) begin failures++; $display("FAIL error_done d=%b e=%b exp=0100/0100", d, er); end
        checks++; if (to !== 1'b0 || lt != 6) begin failures++; $display("FAIL error_to_lat t=%b lat=%0d exp=0/6", to, lt); end
        req = 4'b1011;
        do_txn(2, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++; req = '0; m_ptr = 0;
        checks++; if (g !== 4'b1000) begin failures++; $display("FAIL error_ptr_next act=%b exp=1000", g); end
    endtask

    task automatic test_watchdog();
        logic [N-1:0] g, d, er; logic [W-1:0] c0, c1; int gl, il, lt; logic to; logic [15:0] cn;
        bit bad;
        req = 4'b0001;
        do_txn(0, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++;
        checks++; if (lt != TO) begin failures++; $display("FAIL wd_lat act=%0d exp=%0d", lt, TO); end
        checks++; if (d !== 4'b0001 || er !== 4'b0001 || to !== 1'b1) begin
            failures++; $display("FAIL wd_flags d=%b e=%b t=%b exp=0001/0001/1", d, er, to); end
        eng_auto = 1'b0; eng_done = 1'b1; bad = 1'b0;
        for (int k = 0; k < 4; k++) begin step(); if (done !== '0 || busy !== 1'b0) bad = 1'b1; end
        eng_done = 1'b0; step();
        checks++; if (bad) begin failures++; $display("FAIL wd_idle_edge act=activity exp=none"); end
        req = 4'b0010;
        do_txn(15, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++;
        checks++; if (lt != TO || d !== 4'b0010 || er !== '0 || to !== 1'b0) begin
            failures++; $display("FAIL wd_tie lat=%0d d=%b e=%b t=%b exp=16/0010/0000/0", lt, d, er, to); end
        req = 4'b0100;
        do_txn(16, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++; m_ptr = 3; bad = 1'b0;
        checks++; if (lt != TO || d !== 4'b0100 || er !== 4'b0100 || to !== 1'b1) begin
            failures++; $display("FAIL wd_late lat=%0d d=%b e=%b t=%b exp=16/0100/0100/1", lt, d, er, to); end
        for (int k = 0; k < 4; k++) begin step(); if (done !== '0) bad = 1'b1; end
        checks++; if (bad) begin failures++; $display("FAIL wd_late_edge act=done exp=none"); end
    endtask

    task automatic test_stale_done();
        bit bad;
        eng_auto = 1'b0; eng_done = 1'b1; eng_error = 1'b0;
        req_cmd[0 +: W] = 32'h5A1E_0000; req = 4'b0001;
        step();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL stale_grant act=%b exp=0001", grant); end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin step(); if (done !== '0) bad = 1'b1; end
        eng_done = 1'b0; step(); if (done !== '0) bad = 1'b1;
        checks++; if (bad || busy !== 1'b1) begin failures++; $display("FAIL stale_no_done seen=%b busy=%b exp=0/1", bad, busy); end
        eng_done = 1'b1; step();
        m_count++; m_ptr = 1;
        checks++; if (done !== 4'b0001 || err !== '0 || timeout !== 1'b0) begin
            failures++; $display("FAIL stale_done d=%b e=%b t=%b exp=0001/0000/0", done, err, timeout); end
        checks++; if (txn_count !== 16'(m_count)) begin failures++; $display("FAIL stale_count act=%0d exp=%0d", txn_count, m_count); end
        eng_done = 1'b0; req = '0; step();
    endtask

    task automatic test_reset_wait();
        logic [N-1:0] g, d, er; logic [W-1:0] c0, c1; int gl, il, lt; logic to; logic [15:0] cn;
        req = 4'b0100;
        do_txn(3, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        req_cmd[1*W +: W] = 32'hDEAD_0001; req = 4'b0010;
        eng_auto = 1'b1; eng_delay = 0;
        for (int k = 0; k < 6; k++) step();
        checks++; if (busy !== 1'b1 || eng_init !== 1'b0) begin failures++; $display("FAIL rst_pre_wait busy=%b init=%b exp=1/0", busy, eng_init); end
        req = '0; ARESETN = 1'b0; step();
        checks++; if (grant !== '0 || done !== '0 || err !== '0 || timeout !== 1'b0 || busy !== 1'b0 || eng_init !== 1'b0) begin
            failures++; $display("FAIL rst_wait_ctrl g=%b d=%b e=%b t=%b b=%b i=%b exp=0", grant, done, err, timeout, busy, eng_init); end
        checks++; if (eng_cmd !== '0 || txn_count !== '0) begin
            failures++; $display("FAIL rst_wait_data cmd=%h cnt=%0d exp=0", eng_cmd, txn_count); end
        ARESETN = 1'b1; m_ptr = 0; m_count = 0;
        req_cmd[0 +: W] = 32'h0000_0A0A; req_cmd[3*W +: W] = 32'h3333_0003; req = 4'b1001;
        do_txn(4, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++;
        checks++; if (g !== 4'b0001 || cn !== 16'd1) begin failures++; $display("FAIL rst_ptr_zero g=%b cnt=%0d exp=0001/1", g, cn); end
        do_txn(4, 1'b0, 1'b1, 1'b0, g, c0, c1, gl, il, lt, d, er, to, cn);
        m_count++; m_ptr = 0;
        checks++; if (gl != 1 || g !== 4'b1000 || c0 !== 32'h3333_0003 || d !== 4'b1000) begin
            failures++; $display("FAIL rst_req3 lat=%0d g=%b cmd=%h d=%b exp=1/1000/33330003/1000", gl, g, c0, d); end
    endtask

    task automatic test_random();
        logic [N-1:0] g, d, er, eg, ee; logic [W-1:0] c0, c1, ec; int gl, il, lt; logic to; logic [15:0] cn;
        int own, dly; bit e, sc, eto;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) begin req[i] = 1'b1; req_cmd[i*W +: W] = $urandom; end
            if (req == '0) begin own = $urandom_range(0, N - 1); req[own] = 1'b1; req_cmd[own*W +: W] = $urandom; end
            own = m_pick(req, m_ptr);
            eg = '0; eg[own] = 1'b1;
            ec = req_cmd[own*W +: W];
            if ($urandom_range(0, 4) == 0) dly = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(14, 16);
            else dly = $urandom_range(1, 12);
            e = 1'($urandom_range(0, 1)); sc = 1'($urandom_range(0, 1));
            eto = exp_to(dly);
            ee = (eto || e) ? eg : '0;
            do_txn(dly, e, 1'b1, sc, g, c0, c1, gl, il, lt, d, er, to, cn);
            m_count++; m_ptr = (own + 1) % N;
            checks++; if (g !== eg) begin failures++; $display("FAIL rnd_grant[%0d] act=%b exp=%b", it, g, eg); end
            checks++; if (c0 !== ec || c1 !== ec) begin failures++; $display("FAIL rnd_cmd[%0d] act=%h/%h exp=%h", it, c0, c1, ec); end
            checks++; if (il != IP) begin failures++; $display("FAIL rnd_init_len[%0d] act=%0d exp=%0d", it, il, IP); end
            checks++; if (lt != exp_lat(dly)) begin failures++; $display("FAIL rnd_lat[%0d] d=%0d act=%0d exp=%0d", it, dly, lt, exp_lat(dly)); end
            checks++; if (d !== eg || er !== ee || to !== eto) begin
                failures++; $display("FAIL rnd_resp[%0d] d=%b e=%b t=%b exp=%b/%b/%b", it, d, er, to, eg, ee, eto); end
            checks++; if (cn !== 16'(m_count)) begin failures++; $display("FAIL rnd_count[%0d] act=%0d exp=%0d", it, cn, m_count); end
        end
        req = '0; step();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_error();
        test_watchdog();
        test_stale_done();
        test_reset_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
